// File: rtl/keypad_pkg.sv
// Shared definitions for the 4x4 keypad scanner: FSM encoding, column strobe
// patterns, index width and small line-decoding helpers.
package keypad_pkg;

  localparam int unsigned IDX_W = 2;

  typedef logic [1:0] state_t;

  localparam state_t ST_SCAN     = 2'd0;
  localparam state_t ST_DEBOUNCE = 2'd1;
  localparam state_t ST_PRESSED  = 2'd2;
  localparam state_t ST_RELEASE  = 2'd3;

  localparam logic [3:0] COL0       = 4'b1110;
  localparam logic [3:0] COL1       = 4'b1101;
  localparam logic [3:0] COL2       = 4'b1011;
  localparam logic [3:0] COL3       = 4'b0111;
  localparam logic [3:0] LINES_IDLE = 4'b1111;

  // True when exactly one line of an active-low group is pulled low.
  function automatic logic one_zero(input logic [3:0] v);
    case (v)
      COL0, COL1, COL2, COL3: return 1'b1;
      default:                return 1'b0;
    endcase
  endfunction

  function automatic logic [IDX_W-1:0] zero_idx(input logic [3:0] v);
    case (v)
      COL1:    return 2'd1;
      COL2:    return 2'd2;
      COL3:    return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

  function automatic logic [3:0] next_col(input logic [3:0] c);
    return {c[2:0], c[3]};
  endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// Keypad-side and consumer-side signals of the scanner, grouped as one bundle.
interface keypad_scanner_if;
  logic [3:0]  row;
  logic [3:0]  col;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_held;
  logic [15:0] data_out;

  modport master (
    input  row,
    output col, key_code, key_valid, key_held, data_out
  );

  modport slave (
    output row,
    input  col, key_code, key_valid, key_held, data_out
  );
endinterface

// File: rtl/keypad_tick_gen.sv
// Free-running divider producing a one-clk scan tick every 2^N cycles.
module keypad_tick_gen #(
  parameter int unsigned N = 10
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  logic [N-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_q + 1'b1;
  end

  assign tick = (cnt_q == '1);

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: column strobing, row synchronisation, debounced
// press/release FSM and a four-deep history of accepted key codes.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int unsigned N         = 10,
  parameter int unsigned DEB_TICKS = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  keypad_scanner_if.master kp
);

  localparam int unsigned DEB_W = $clog2(DEB_TICKS + 1);

  logic             tick;
  logic [3:0]       rs_meta_q, rs_q;
  state_t           state_q, state_d;
  logic [3:0]       col_q, col_d;
  logic [3:0]       ref_q, ref_d;
  logic [DEB_W-1:0] deb_q, deb_d, deb_inc;
  logic [3:0]       code_q, code_d, new_code;
  logic             valid_q, valid_d;
  logic             held_q, held_d;
  logic [15:0]      data_q, data_d;

  keypad_tick_gen #(.N(N)) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (tick)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rs_meta_q <= LINES_IDLE;
      rs_q      <= LINES_IDLE;
    end else begin
      rs_meta_q <= kp.row;
      rs_q      <= rs_meta_q;
    end
  end

  assign deb_inc  = deb_q + 1'b1;
  assign new_code = {zero_idx(ref_q), zero_idx(col_q)};

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    ref_d   = ref_q;
    deb_d   = deb_q;
    code_d  = code_q;
    valid_d = 1'b0;
    held_d  = held_q;
    data_d  = data_q;
    if (tick) begin
      case (state_q)
        ST_SCAN: begin
          // Multi-key (ghosting) patterns fall through to rotation like idle.
          if (one_zero(rs_q)) begin
            ref_d   = rs_q;
            deb_d   = DEB_W'(1);
            state_d = ST_DEBOUNCE;
          end else begin
            col_d = next_col(col_q);
          end
        end
        ST_DEBOUNCE: begin
          if (rs_q == ref_q) begin
            deb_d = deb_inc;
            if (deb_inc >= DEB_W'(DEB_TICKS)) begin
              state_d = ST_PRESSED;
              code_d  = new_code;
              valid_d = 1'b1;
              held_d  = 1'b1;
              data_d  = {data_q[11:0], new_code};
            end
          end else begin
            state_d = ST_SCAN;
          end
        end
        ST_PRESSED: begin
          if (rs_q == LINES_IDLE) begin
            deb_d   = DEB_W'(1);
            state_d = ST_RELEASE;
          end
        end
        ST_RELEASE: begin
          if (rs_q == LINES_IDLE) begin
            deb_d = deb_inc;
            if (deb_inc >= DEB_W'(DEB_TICKS)) begin
              state_d = ST_SCAN;
              held_d  = 1'b0;
              col_d   = next_col(col_q);
            end
          end else begin
            state_d = ST_PRESSED;
          end
        end
        default: state_d = ST_SCAN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_SCAN;
      col_q   <= COL0;
      ref_q   <= LINES_IDLE;
      deb_q   <= '0;
      code_q  <= '0;
      valid_q <= 1'b0;
      held_q  <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      ref_q   <= ref_d;
      deb_q   <= deb_d;
      code_q  <= code_d;
      valid_q <= valid_d;
      held_q  <= held_d;
      data_q  <= data_d;
    end
  end

  assign kp.col       = col_q;
  assign kp.key_code  = code_q;
  assign kp.key_valid = valid_q;
  assign kp.key_held  = held_q;
  assign kp.data_out  = data_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a physical keypad model and a
// scoreboard of expected key codes checked on every key_valid pulse.
module tb_keypad_scanner;

  logic clk;
  logic rst_n;

  keypad_scanner_if kp ();

  keypad_scanner #(.N(2), .DEB_TICKS(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .kp    (kp)
  );

  logic       key_down;
  logic [1:0] key_r, key_c;
  logic       force_en;
  logic [3:0] force_row;
  logic [3:0] row_drv;

  // Keypad matrix: a held key pulls its row low only while its column is strobed.
  always_comb begin
    row_drv = 4'hF;
    if (force_en) row_drv = force_row;
    else if (key_down && (kp.col[key_c] == 1'b0)) row_drv[key_r] = 1'b0;
  end
  assign kp.row = row_drv;

  int n_cmp  = 0;
  int n_fail = 0;
  int n_valid = 0;
  logic [3:0]  exp_q[$];
  logic [15:0] exp_data = 16'h0000;
  logic        prev_valid = 1'b0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every key_valid pulse must match the oldest outstanding press.
  always @(negedge clk) begin
    if (prev_valid) check("valid_pulse_width", 16'(kp.key_valid), 16'd0);
    if (kp.key_valid === 1'b1) begin
      n_valid++;
      if (exp_q.size() == 0) begin
        check("unexpected_valid", 16'(kp.key_valid), 16'd0);
      end else begin
        logic [3:0] c;
        c = exp_q.pop_front();
        exp_data = {exp_data[11:0], c};
        check("key_code", 16'(kp.key_code), 16'(c));
        check("data_out", kp.data_out, exp_data);
        check("held_on_valid", 16'(kp.key_held), 16'd1);
      end
    end
    prev_valid = kp.key_valid;
  end

  task automatic press(input logic [3:0] code);
    key_r = code[3:2];
    key_c = code[1:0];
    exp_q.push_back(code);
    key_down = 1'b1;
  endtask

  task automatic wait_valid(input int base, input string tag);
    int i = 0;
    while (n_valid == base && i < 200) begin
      @(negedge clk);
      i++;
    end
    check(tag, 16'(n_valid > base), 16'd1);
  endtask

  task automatic wait_held_low(input string tag);
    int i = 0;
    while (kp.key_held !== 1'b0 && i < 200) begin
      @(negedge clk);
      i++;
    end
    check(tag, 16'(kp.key_held), 16'd0);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_col"},      16'(kp.col), 16'h000E);
    check({tag, "_key_code"}, 16'(kp.key_code), 16'd0);
    check({tag, "_valid"},    16'(kp.key_valid), 16'd0);
    check({tag, "_held"},     16'(kp.key_held), 16'd0);
    check({tag, "_data_out"}, kp.data_out, 16'h0000);
  endtask

  initial begin
    logic [3:0] seq [5];
    logic [3:0] colv, expc;
    int base, i;
    logic [3:0] col_seq [4];
    seq     = '{4'h1, 4'h2, 4'h3, 4'hA, 4'hF};
    col_seq = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

    rst_n = 1'b0; key_down = 1'b0; key_r = 2'd0; key_c = 2'd0;
    force_en = 1'b0; force_row = 4'hF;
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    rst_n = 1'b1;

    // Idle rotation: column changes on every fourth clock after reset.
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      check($sformatf("idle_col_%0d", k), 16'(kp.col), 16'(col_seq[(k / 4) % 4]));
    end
    check("idle_data_out", kp.data_out, 16'h0000);

    // Key 6 held for 10 ticks, then released.
    base = n_valid;
    press(4'h6);
    repeat (40) @(negedge clk);
    check("k6_single_valid", 16'(n_valid - base), 16'd1);
    check("k6_held", 16'(kp.key_held), 16'd1);
    check("k6_data_out", kp.data_out, 16'h0006);
    key_down = 1'b0;
    wait_held_low("k6_release");
    check("k6_col_after_release", 16'(kp.col), 16'h0007);

    // Five clean presses.
    for (int k = 0; k < 5; k++) begin
      base = n_valid;
      press(seq[k]);
      wait_valid(base, $sformatf("seq_valid_%0d", k));
      repeat (8) @(negedge clk);
      key_down = 1'b0;
      wait_held_low($sformatf("seq_release_%0d", k));
    end
    check("seq_data_out", kp.data_out, 16'h23AF);

    // Bounce: one-tick-wide low pulses never get accepted.
    base = n_valid;
    force_en = 1'b1;
    for (int k = 0; k < 5; k++) begin
      force_row = 4'b1110;
      repeat (4) @(negedge clk);
      force_row = 4'b1111;
      repeat (4) @(negedge clk);
    end
    repeat (8) @(negedge clk);
    check("bounce_no_valid", 16'(n_valid - base), 16'd0);
    check("bounce_held", 16'(kp.key_held), 16'd0);

    // Two keys on one column line: ghost pattern keeps the scan rotating.
    force_row = 4'b1100;
    repeat (8) @(negedge clk);
    colv = kp.col;
    i = 0;
    while (kp.col === colv && i < 8) begin
      @(negedge clk);
      i++;
    end
    check("ghost_col_moves", 16'(kp.col !== colv), 16'd1);
    for (int k = 0; k < 4; k++) begin
      colv = kp.col;
      expc = {colv[2:0], colv[3]};
      repeat (4) @(negedge clk);
      check($sformatf("ghost_rot_%0d", k), 16'(kp.col), 16'(expc));
    end
    check("ghost_no_valid", 16'(n_valid - base), 16'd0);
    force_en = 1'b0;
    force_row = 4'hF;
    repeat (8) @(negedge clk);

    // Reset in the middle of debouncing key 5.
    base = n_valid;
    key_r = 2'd1; key_c = 2'd1; key_down = 1'b1;
    i = 0;
    while (kp.col === 4'b1101 && i < 40) begin
      @(negedge clk);
      i++;
    end
    i = 0;
    while (kp.col !== 4'b1101 && i < 40) begin
      @(negedge clk);
      i++;
    end
    check("k5_col_reached", 16'(kp.col), 16'h000D);
    repeat (6) @(negedge clk);
    check("k5_no_valid_before_rst", 16'(n_valid - base), 16'd0);
    rst_n = 1'b0;
    exp_data = 16'h0000;
    @(negedge clk);
    check_reset_vals("midrst");
    rst_n = 1'b1;
    exp_q.push_back(4'h5);
    wait_valid(base, "k5_valid_after_rst");
    repeat (40) @(negedge clk);
    check("k5_single_valid", 16'(n_valid - base), 16'd1);
    key_down = 1'b0;
    wait_held_low("k5_release");

    check("scoreboard_drained", 16'(exp_q.size()), 16'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
